// File: rtl/pll_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_seq_pkg
// Description : Shared definitions for the PLL lock sequencer. Holds the
//               sequencer state encoding and the helper that sizes the
//               shared cycle counter from the timing parameters.
// Revision    : 1.0 - initial release
// ============================================================================
package pll_seq_pkg;

    // Sequencer states, explicitly encoded.
    typedef enum logic [2:0] {
        ST_RST_PLL   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } pll_state_t;

    // Width of a counter that must reach (max(a, b, c) - 1) without wrapping.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : 1-bit two-flop synchronizer. The output lags the input by
//               two clk edges. Both flops load RST_VAL under reset.
// Ports       : clk  - destination clock
//               rst  - synchronous active-high reset
//               i_d  - asynchronous input
//               o_q  - synchronized output
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_sequencer
// Description : Brings up a PLL and holds the DDR3 controller domain in reset
//               until the (synchronized) PLL lock has been stable long enough.
//               Retries timed-out lock attempts, gives up after MAX_RETRIES,
//               and re-sequences on lock loss or a restart request.
// Ports       : clk         - reference clock
//               reset       - synchronous active-high reset
//               lock        - PLL lock, asynchronous to clk
//               restart     - single-cycle re-sequence request
//               pll_reset   - PLL reset, active-high
//               ddr_rst     - DDR3 controller domain reset, active-high
//               ready       - high only in RUN
//               fail        - high only in FAIL
//               loss_count  - lock losses seen in RUN, saturating at 255
//               retry_count - timed-out attempts in the current sequence
// Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int LOCK_STABLE    = 1000,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lock,
    input  logic       restart,
    output logic       pll_reset,
    output logic       ddr_rst,
    output logic       ready,
    output logic       fail,
    output logic [7:0] loss_count,
    output logic [3:0] retry_count
);

    localparam int c_cnt_w = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);

    localparam logic [c_cnt_w-1:0] c_rst_last     = c_cnt_w'(PLL_RST_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(LOCK_TIMEOUT - 1);
    // The WAIT_LOCK cycle that first sees lock_s=1 is the first of the
    // LOCK_STABLE consecutive locked cycles, so STABLE itself needs
    // LOCK_STABLE-1 more; the counter starts at 0 on entry.
    localparam logic [c_cnt_w-1:0] c_stable_last  = c_cnt_w'(LOCK_STABLE - 2);
    localparam logic [3:0]         c_max_retries  = 4'(MAX_RETRIES);

    logic               w_lock_s;

    pll_state_t         r_state;
    pll_state_t         w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [3:0]         r_retry;
    logic [3:0]         w_retry_nxt;
    logic [3:0]         w_retry_inc;
    logic [7:0]         r_loss;
    logic [7:0]         w_loss_nxt;

    logic               r_pll_reset;
    logic               r_ddr_rst;
    logic               r_ready;
    logic               r_fail;

    sync_2ff #(
        .RST_VAL (1'b0)
    ) u_lock_sync (
        .clk (clk),
        .rst (reset),
        .i_d (lock),
        .o_q (w_lock_s)
    );

    assign w_retry_inc = r_retry + 4'd1;

    // State, counter and counts register. Outputs are registered from the
    // next state so they always match the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RST_PLL;
            r_cnt       <= '0;
            r_retry     <= 4'd0;
            r_loss      <= 8'd0;
            r_pll_reset <= 1'b1;
            r_ddr_rst   <= 1'b1;
            r_ready     <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_retry     <= w_retry_nxt;
            r_loss      <= w_loss_nxt;
            r_pll_reset <= (w_state_nxt == ST_RST_PLL) || (w_state_nxt == ST_FAIL);
            r_ddr_rst   <= (w_state_nxt != ST_RUN);
            r_ready     <= (w_state_nxt == ST_RUN);
            r_fail      <= (w_state_nxt == ST_FAIL);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_retry_nxt = r_retry;
        w_loss_nxt  = r_loss;

        // restart wins over any lock_s event in the same cycle, so a
        // simultaneous drop in RUN is not counted as a loss.
        if (restart) begin
            w_state_nxt = ST_RST_PLL;
            w_cnt_nxt   = '0;
            w_retry_nxt = 4'd0;
        end else begin
            unique case (r_state)
                ST_RST_PLL: begin
                    if (r_cnt == c_rst_last) begin
                        w_state_nxt = ST_WAIT_LOCK;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (w_lock_s) begin
                        w_state_nxt = ST_STABLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_timeout_last) begin
                        w_retry_nxt = w_retry_inc;
                        w_cnt_nxt   = '0;
                        w_state_nxt = (w_retry_inc == c_max_retries) ? ST_FAIL : ST_RST_PLL;
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end
                ST_STABLE: begin
                    if (!w_lock_s) begin
                        w_state_nxt = ST_WAIT_LOCK;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_stable_last) begin
                        w_state_nxt = ST_RUN;
                        w_cnt_nxt   = '0;
                        w_retry_nxt = 4'd0;
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!w_lock_s) begin
                        w_state_nxt = ST_RST_PLL;
                        w_cnt_nxt   = '0;
                        if (r_loss != 8'hFF) begin
                            w_loss_nxt = r_loss + 8'd1;
                        end
                    end
                end
                ST_FAIL: begin
                    w_state_nxt = ST_FAIL;
                end
                default: begin
                    w_state_nxt = ST_RST_PLL;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign pll_reset   = r_pll_reset;
    assign ddr_rst     = r_ddr_rst;
    assign ready       = r_ready;
    assign fail        = r_fail;
    assign loss_count  = r_loss;
    assign retry_count = r_retry;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_lock_sequencer
// Description : Self-checking bench for pll_lock_sequencer with
//               PLL_RST_CYCLES=4, LOCK_TIMEOUT=100, LOCK_STABLE=16,
//               MAX_RETRIES=3. Inputs change and outputs are sampled on the
//               falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_lock_sequencer;

    logic       clk;
    logic       reset;
    logic       lock;
    logic       restart;
    logic       pll_reset;
    logic       ddr_rst;
    logic       ready;
    logic       fail;
    logic [7:0] loss_count;
    logic [3:0] retry_count;

    int n_pass;
    int n_total;

    pll_lock_sequencer #(
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (100),
        .LOCK_STABLE    (16),
        .MAX_RETRIES    (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .lock        (lock),
        .restart     (restart),
        .pll_reset   (pll_reset),
        .ddr_rst     (ddr_rst),
        .ready       (ready),
        .fail        (fail),
        .loss_count  (loss_count),
        .retry_count (retry_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output vector layout: {pll_reset, ddr_rst, ready, fail, loss[7:0], retry[3:0]}
    typedef struct {
        logic        rst;
        logic        rs;
        logic        lk;
        int          cyc;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(input logic rst, input logic rs, input logic lk, input int cyc,
                                input logic p, input logic d, input logic r, input logic f,
                                input logic [7:0] loss, input logic [3:0] retry);
        vec_t v;
        v.rst = rst;
        v.rs  = rs;
        v.lk  = lk;
        v.cyc = cyc;
        v.exp = {p, d, r, f, loss, retry};
        return v;
    endfunction

    function automatic logic [15:0] outs();
        return {pll_reset, ddr_rst, ready, fail, loss_count, retry_count};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Count consecutive falling-edge samples where pll_reset equals val.
    task automatic run_len(input logic val, input int bound, output int n);
        n = 0;
        while (pll_reset === val && n < bound) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Count falling edges until ready is seen high.
    task automatic wait_ready(input int bound, output int n);
        n = 0;
        while (ready !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] exp_loss;

        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        restart = 1'b0;
        lock    = 1'b0;

        //           rst  rs   lk  cyc  pll  ddr  rdy  fail loss retry
        vecs[0]  = mk(1'b1,1'b0,1'b0, 2, 1'b1,1'b1,1'b0,1'b0,8'd0,4'd0); // reset values
        vecs[1]  = mk(1'b0,1'b0,1'b0, 3, 1'b1,1'b1,1'b0,1'b0,8'd0,4'd0); // RST_PLL counting
        vecs[2]  = mk(1'b0,1'b0,1'b0, 1, 1'b0,1'b1,1'b0,1'b0,8'd0,4'd0); // WAIT_LOCK
        vecs[3]  = mk(1'b0,1'b0,1'b1, 1, 1'b0,1'b1,1'b0,1'b0,8'd0,4'd0); // sync stage 1
        vecs[4]  = mk(1'b0,1'b0,1'b1, 1, 1'b0,1'b1,1'b0,1'b0,8'd0,4'd0); // lock_s up
        vecs[5]  = mk(1'b0,1'b0,1'b1, 1, 1'b0,1'b1,1'b0,1'b0,8'd0,4'd0); // STABLE entered
        vecs[6]  = mk(1'b0,1'b0,1'b1,14, 1'b0,1'b1,1'b0,1'b0,8'd0,4'd0); // still STABLE
        vecs[7]  = mk(1'b0,1'b0,1'b1, 1, 1'b0,1'b0,1'b1,1'b0,8'd0,4'd0); // RUN, 18 edges after lock
        vecs[8]  = mk(1'b0,1'b0,1'b0, 1, 1'b0,1'b0,1'b1,1'b0,8'd0,4'd0); // drop in sync
        vecs[9]  = mk(1'b0,1'b0,1'b0, 1, 1'b0,1'b0,1'b1,1'b0,8'd0,4'd0); // lock_s low
        vecs[10] = mk(1'b0,1'b0,1'b0, 1, 1'b1,1'b1,1'b0,1'b0,8'd1,4'd0); // loss, RST_PLL
        vecs[11] = mk(1'b0,1'b0,1'b0, 4, 1'b0,1'b1,1'b0,1'b0,8'd1,4'd0); // back to WAIT
        vecs[12] = mk(1'b0,1'b1,1'b0, 1, 1'b1,1'b1,1'b0,1'b0,8'd1,4'd0); // restart keeps loss
        vecs[13] = mk(1'b1,1'b0,1'b0, 1, 1'b1,1'b1,1'b0,1'b0,8'd0,4'd0); // reset clears loss

        for (int i = 0; i < 14; i++) begin
            reset   = vecs[i].rst;
            restart = vecs[i].rs;
            lock    = vecs[i].lk;
            repeat (vecs[i].cyc) @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d", i), {16'd0, outs()}, {16'd0, vecs[i].exp});
        end

        // No lock: three attempts of 4 + 100 cycles, then FAIL.
        reset   = 1'b0;
        restart = 1'b1;
        lock    = 1'b0;
        @(negedge clk);
        restart = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            run_len(1'b1, 20, n);
            check($sformatf("attempt%0d_rst_len", k), n, 4);
            run_len(1'b0, 200, n);
            check($sformatf("attempt%0d_wait_len", k), n, 100);
            check($sformatf("attempt%0d_retry", k), {28'd0, retry_count}, k);
        end
        check("fail_state", {16'd0, outs()}, {16'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0, 4'd3});
        repeat (5) @(negedge clk);
        check("fail_held", {30'd0, fail, pll_reset}, {30'd0, 2'b11});
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("fail_restart", {16'd0, outs()}, {16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 4'd0});

        // Lock chatter during STABLE returns to WAIT_LOCK without a retry.
        run_len(1'b1, 20, n);
        check("chatter_rst_len", n, 4);
        lock = 1'b1;
        repeat (12) @(negedge clk);
        lock = 1'b0;
        repeat (3) @(negedge clk);
        check("chatter_wait", {16'd0, outs()}, {16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 4'd0});
        lock = 1'b1;
        wait_ready(100, n);
        check("chatter_relock_latency", n, 18);

        // restart and a lock_s drop in the same RUN cycle: no loss counted.
        lock = 1'b0;
        repeat (2) @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("restart_vs_drop", {16'd0, outs()}, {16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 4'd0});
        lock = 1'b1;
        wait_ready(100, n);
        check("restart_relock_latency", n, 20);

        // 300 single drops in RUN: loss_count saturates at 255.
        for (int i = 0; i < 300; i++) begin
            exp_loss = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
            lock = 1'b0;
            n = 0;
            while (ddr_rst !== 1'b1 && n < 10) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("drop%0d", i), {16'd0, 8'(n), loss_count}, {16'd0, 8'd3, exp_loss});
            lock = 1'b1;
            wait_ready(100, n);
            check($sformatf("drop%0d_relock", i), {31'd0, ready}, 32'd1);
        end

        // reset asserted in STABLE.
        lock = 1'b0;
        n = 0;
        while (pll_reset !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        run_len(1'b1, 20, n);
        lock = 1'b1;
        repeat (5) @(negedge clk);
        check("stable_before_reset", {16'd0, outs()}, {16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd255, 4'd0});
        reset = 1'b1;
        @(negedge clk);
        check("reset_in_stable", {16'd0, outs()}, {16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 4'd0});
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
